hc165_reader: RTL
=================

Name: hc165_reader

Overview:
- Serial input-expander reader for a 74HC165 parallel-in/serial-out shift-register chain.
- Counterpart of the 74HC595 segment-display writer. It periodically loads the chain, shifts the bits in, and debounces each bit.
- Presents a stable vector plus per-scan and per-change strobes.
- Sits beside the display driver on sys_clk (50 MHz). It feeds key/switch state to the processor input PIO instead of raw key pins.

Parameters:
- NUM_BITS, 8, chain length in bits (multiple of 8, 8..32).
- CLK_DIV, 25, sys_clk cycles per sr_clk half-period (>=2).
- SCAN_PERIOD, 50000, sys_clk cycles between scan starts (must exceed (2*NUM_BITS+1)*CLK_DIV+2).
- DEBOUNCE_SCANS, 4, consecutive identical scans required before a data bit changes (>=1).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- sr_clk  out  1  165 CLK; idles low
- sr_ld_n  out  1  165 SH/LD_n; low loads parallel inputs; idles high
- sr_dat  in  1  165 QH, serial data from the last chip in the chain
- raw  out  NUM_BITS  last completed scan, undebounced
- data  out  NUM_BITS  debounced vector
- scan_done  out  1  one-cycle pulse when raw updates
- changed  out  1  one-cycle pulse, coincident with any data bit update

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is asynchronous and active-high.
- Reset values: sr_clk=0, sr_ld_n=1, raw=0, data=0, scan_done=0, changed=0. All counters are 0, state=IDLE.
- Reset asserted mid-scan aborts immediately; the partial shift is discarded.
- Scan timer:
  - Free-running, 0..SCAN_PERIOD-1.
  - A scan starts when the timer wraps.
  - The first sr_ld_n fall occurs SCAN_PERIOD cycles after reset deassertion.
- FSM states: IDLE -> LOAD -> SETTLE -> SHIFT_LO -> SHIFT_HI -> ... -> DONE -> IDLE.
- IDLE: outputs at idle levels; wait for timer wrap.
- LOAD: sr_ld_n=0 for CLK_DIV cycles.
- SETTLE: sr_ld_n=1, sr_clk=0 for CLK_DIV cycles.
- SHIFT_LO: sr_clk=0 for CLK_DIV cycles.
  - On the last cycle, sample sr_dat into the shift register (shift left, new bit in LSB).
  - Increment the bit counter.
  - If the bit counter reaches NUM_BITS, go to DONE; otherwise go to SHIFT_HI.
- SHIFT_HI: sr_clk=1 for CLK_DIV cycles, then SHIFT_LO.
  - Exactly NUM_BITS-1 rising edges occur per scan.
- Bit order: the first sampled bit (the H input of the chip nearest sr_dat) lands in raw[NUM_BITS-1]. The last sampled bit lands in raw[0].
- DONE (1 cycle): raw <= shift register and scan_done=1 next cycle, then IDLE.
  - Scan length from sr_ld_n fall to DONE is (2*NUM_BITS+1)*CLK_DIV cycles.
- Debounce, per bit, evaluated in DONE against the new sample:
  - If the sample equals data[i], reset the count.
  - Otherwise increment the count. When the count reaches DEBOUNCE_SCANS, data[i] <= sample and the count clears.
  - With DEBOUNCE_SCANS=1, data follows raw.
- changed pulses in the same cycle as scan_done when at least one data bit flipped.
- Timer wrap while a scan is in progress is a parameter violation; the scan is not restarted and the wrap is ignored.
- No combinational path from sr_dat to any output. All outputs are registered.

Decomposition:
- Shared package hc165_pkg holds:
  - the FSM state enum;
  - default constants (CLK_DIV_DEFAULT, SCAN_PERIOD_DEFAULT);
  - a clog2-based width function for the counters.
- One natural sub-module: hc165_debounce. It is the NUM_BITS-wide per-bit counter bank with an update strobe, sample in, and data/changed out. It is reusable for direct key pins.

Test Plan:
Benches model a 165 chain; default sim parameters are NUM_BITS=8, CLK_DIV=2, SCAN_PERIOD=64, DEBOUNCE_SCANS=3.
- Reset release -> all outputs 0, sr_ld_n high; first sr_ld_n low at cycle 64, low for 2 cycles; scan_done at cycle 64+34+1.
- Chain holds 0xA5 -> raw=0xA5 after scan 1; data=0xA5 and changed=1 only at the scan_done of scan 3; scan 4 gives changed=0.
- Inputs toggle bit0 for one scan only (0xA5 -> 0xA4 -> 0xA5) -> raw shows 0xA4 once; data stays 0xA5; no changed pulse.
- Waveform check per scan -> exactly 7 sr_clk rising edges, each half-period 2 cycles, sr_clk low whenever sr_ld_n low, sampling of sr_dat before each rising edge.
- sys_rst asserted after the 3rd rising edge -> same cycle sr_clk=0, sr_ld_n=1, raw/data=0; next sr_ld_n fall 64 cycles after release.
- NUM_BITS=16, chain inputs 0x1234, DEBOUNCE_SCANS=1 -> raw=data=0x1234 after first scan, 15 rising edges, MSB-first order confirmed.

Source files
------------

// File: rtl/hc165_pkg.sv
// Shared types and constants for the 74HC165 input-expander reader.
package hc165_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    localparam int unsigned CLK_DIV_DEFAULT     = 25;
    localparam int unsigned SCAN_PERIOD_DEFAULT = 50000;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hc165_debounce.sv
// Per-bit scan-count debouncer; data bit flips after DEBOUNCE_SCANS consecutive disagreeing samples.
module hc165_debounce
    import hc165_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] data,
    output logic             changed
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_SCANS);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] data_d;
    logic             changed_d;

    always_comb begin
        data_d    = data;
        changed_d = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (update) begin
                if (sample[i] == data[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_SCANS - 1)) begin
                    cnt_d[i]  = '0;
                    data_d[i] = sample[i];
                    changed_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            changed <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            data    <= data_d;
            changed <= changed_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/hc165_reader.sv
// Periodic 74HC165 chain scanner: load, shift in MSB-first, publish raw and debounced vectors.
module hc165_reader
    import hc165_pkg::*;
#(
    parameter int unsigned NUM_BITS       = 8,
    parameter int unsigned CLK_DIV        = CLK_DIV_DEFAULT,
    parameter int unsigned SCAN_PERIOD    = SCAN_PERIOD_DEFAULT,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    output logic                sr_clk,
    output logic                sr_ld_n,
    input  logic                sr_dat,
    output logic [NUM_BITS-1:0] raw,
    output logic [NUM_BITS-1:0] data,
    output logic                scan_done,
    output logic                changed
);

    localparam int unsigned TW = cnt_width(SCAN_PERIOD - 1);
    localparam int unsigned DW = cnt_width(CLK_DIV - 1);
    localparam int unsigned BW = cnt_width(NUM_BITS);

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [NUM_BITS-1:0] raw_d;
    logic                sr_clk_d, sr_ld_n_d, scan_done_d;
    logic                wrap, div_last, db_update;

    assign wrap     = (timer_q == TW'(SCAN_PERIOD - 1));
    assign div_last = (div_q == DW'(CLK_DIV - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer_q <= '0;
        end else if (wrap) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_last ? '0 : div_q + DW'(1);
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        raw_d       = raw;
        scan_done_d = 1'b0;
        db_update   = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                // A wrap seen outside IDLE is simply dropped; scans never restart mid-flight.
                if (wrap) begin
                    state_d = LOAD;
                    bit_d   = '0;
                end
            end
            LOAD: begin
                if (div_last) state_d = SETTLE;
            end
            SETTLE: begin
                if (div_last) state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_last) begin
                    shreg_d = {shreg_q[NUM_BITS-2:0], sr_dat};
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BW'(NUM_BITS - 1)) ? DONE : SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (div_last) state_d = SHIFT_LO;
            end
            DONE: begin
                raw_d       = shreg_q;
                scan_done_d = 1'b1;
                db_update   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pin levels are decoded from the next state so they land in flops aligned with it.
        sr_ld_n_d = (state_d != LOAD);
        sr_clk_d  = (state_d == SHIFT_HI);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            raw       <= '0;
            scan_done <= 1'b0;
            sr_clk    <= 1'b0;
            sr_ld_n   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            raw       <= raw_d;
            scan_done <= scan_done_d;
            sr_clk    <= sr_clk_d;
            sr_ld_n   <= sr_ld_n_d;
        end
    end

    hc165_debounce #(
        .WIDTH          (NUM_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .update  (db_update),
        .sample  (shreg_q),
        .data    (data),
        .changed (changed)
    );

endmodule
